// File: rtl/matrix_result_tx_pkg.sv
// Shared definitions for the matrix result framer: FSM states, frame constants
// and the frame-length helper.
package matrix_result_tx_pkg;

  localparam logic [7:0]  HEADER_BYTE = 8'hA5;
  localparam int unsigned MAX_N       = 3;
  localparam int unsigned ELEM_W      = 16;
  localparam int unsigned RESULT_W    = 144;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    WAIT_DONE,
    DONE
  } state_t;

  // header + size + 2 bytes per element + checksum
  function automatic logic [4:0] frame_len(input logic [3:0] n);
    return 5'(3 + 2 * int'(n) * int'(n));
  endfunction

endpackage

// File: rtl/matrix_elem_sel.sv
// Picks one byte of a stride-3, row-major 16-bit element from the result vector.
module matrix_elem_sel
  import matrix_result_tx_pkg::*;
(
  input  logic [RESULT_W-1:0] result,
  input  logic [1:0]          row,
  input  logic [1:0]          col,
  input  logic                hi,
  output logic [7:0]          data
);

  logic [3:0]        k;
  logic [ELEM_W-1:0] elem;

  always_comb begin
    k    = ({2'b00, row} * 4'd3) + {2'b00, col};
    elem = '0;
    for (int unsigned i = 0; i < MAX_N * MAX_N; i++) begin
      if (k == 4'(i)) elem = result[i*ELEM_W +: ELEM_W];
    end
    data = hi ? elem[15:8] : elem[7:0];
  end

endmodule

// File: rtl/matrix_result_tx.sv
// Frames the latched N x N product as header, size, data bytes and XOR checksum
// and hands it byte by byte to uart_tx with a start/busy handshake.
module matrix_result_tx
  import matrix_result_tx_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                bclk,
  input  logic                rst,
  input  logic                load,
  input  logic [RESULT_W-1:0] result,
  input  logic [3:0]          size,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t              state, state_nx;
  logic [RESULT_W-1:0] res_q;
  logic [3:0]          n_q;
  logic [4:0]          b_idx, last_idx;
  logic [1:0]          row, col;
  logic                hi;
  logic [7:0]          chk, cur_byte, elem_byte, tx_data_q;
  logic [CNT_W-1:0]    ack_cnt;
  logic                err_q, size_ok, is_data, ack_expired;

  assign size_ok     = (size != 4'd0) && (size <= 4'(MAX_N));
  assign last_idx    = frame_len(n_q) - 5'd1;
  assign is_data     = (b_idx >= 5'd2) && (b_idx != last_idx);
  assign ack_expired = (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));

  matrix_elem_sel u_elem_sel (
    .result (res_q),
    .row    (row),
    .col    (col),
    .hi     (hi),
    .data   (elem_byte)
  );

  always_comb begin
    if (b_idx == 5'd0)         cur_byte = HEADER_BYTE;
    else if (b_idx == 5'd1)    cur_byte = {4'h0, n_q};
    else if (b_idx == last_idx) cur_byte = chk;
    else                       cur_byte = elem_byte;
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (load && size_ok) state_nx = SEND;
      SEND:      state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy)          state_nx = WAIT_DONE;
        else if (ack_expired) state_nx = SEND;
      end
      WAIT_DONE: if (!tx_busy) state_nx = (b_idx == last_idx) ? DONE : SEND;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // tx_data follows the live byte in SEND and is held by tx_data_q afterwards
  always_comb begin
    tx_start = (state == SEND);
    busy     = (state == SEND) || (state == WAIT_ACK) || (state == WAIT_DONE);
    done     = (state == DONE);
    tx_data  = (state == SEND) ? cur_byte : tx_data_q;
    err      = err_q;
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      n_q       <= '0;
      b_idx     <= '0;
      row       <= '0;
      col       <= '0;
      hi        <= 1'b0;
      chk       <= '0;
      tx_data_q <= '0;
      ack_cnt   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load && size_ok) begin
            res_q <= result;
            n_q   <= size;
            b_idx <= '0;
            row   <= '0;
            col   <= '0;
            hi    <= 1'b1;
            chk   <= '0;
            err_q <= 1'b0;
          end else if (load) begin
            err_q <= 1'b1;
          end
        end
        SEND: begin
          ack_cnt   <= '0;
          tx_data_q <= cur_byte;
        end
        WAIT_ACK: begin
          if (!tx_busy) begin
            if (ack_expired) err_q   <= 1'b1;
            else             ack_cnt <= ack_cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy && (b_idx != last_idx)) begin
            b_idx <= b_idx + 5'd1;
            if (is_data) begin
              chk <= chk ^ cur_byte;
              hi  <= ~hi;
              if (!hi) begin
                if ({2'b00, col} == n_q - 4'd1) begin
                  col <= '0;
                  row <= row + 2'd1;
                end else begin
                  col <= col + 2'd1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_tx.sv
// Self-checking bench for matrix_result_tx: a uart_tx responder records every
// accepted byte and frames are compared against a byte-list reference model.
module tb_matrix_result_tx;

  logic         bclk = 1'b0;
  logic         rst, load, tx_busy, tx_start, busy, done, err;
  logic [143:0] result;
  logic [3:0]   size;
  logic [7:0]   tx_data;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int drop_at = -1;
  int busy_len = 10;
  logic [7:0] got_q[$], start_q[$], exp_q[$];

  always #5 bclk = ~bclk;

  matrix_result_tx #(.ACK_TIMEOUT(16)) dut (
    .bclk     (bclk),
    .rst      (rst),
    .load     (load),
    .result   (result),
    .size     (size),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // uart_tx model: accepts a start (unless told to drop it) and stays busy busy_len cycles
  initial begin
    logic [7:0] lat;
    tx_busy = 1'b0;
    forever begin
      @(negedge bclk);
      if (tx_start && !rst) begin
        start_cnt++;
        start_q.push_back(tx_data);
        if (start_cnt != drop_at) begin
          lat = tx_data;
          got_q.push_back(tx_data);
          tx_busy = 1'b1;
          for (int i = 0; i < busy_len; i++) begin
            @(negedge bclk);
            if (rst) break;
            tests++;
            if (tx_data !== lat) begin
              fails++;
              $display("FAIL tx_data_stable got %h exp %h", tx_data, lat);
            end
          end
          tx_busy = 1'b0;
        end
      end
    end
  end

  task automatic build_expected(input logic [143:0] res, input int n);
    logic [15:0] e;
    logic [7:0]  x;
    exp_q = {};
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n));
    x = 8'h00;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        e = res[16*(3*r+c) +: 16];
        exp_q.push_back(e[15:8]);
        exp_q.push_back(e[7:0]);
        x = x ^ e[15:8] ^ e[7:0];
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic clear_obs();
    got_q = {};
    start_q = {};
    start_cnt = 0;
    drop_at = -1;
  endtask

  task automatic rand_result(output logic [143:0] res);
    for (int k = 0; k < 9; k++) res[16*k +: 16] = 16'($urandom);
  endtask

  task automatic pulse_load(input logic [143:0] res, input int n);
    @(negedge bclk);
    result = res;
    size   = 4'(n);
    load   = 1'b1;
    @(negedge bclk);
    load   = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge bclk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; size = '0; result = '0;
    repeat (3) @(negedge bclk);
    tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 1'b0;
    @(negedge bclk);
  endtask

  task automatic test_n2_fixed();
    logic [143:0] res;
    logic [7:0]   lit [11];
    bit           ok;
    lit = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    rand_result(res);
    res[16*0 +: 16] = 16'h0102;
    res[16*1 +: 16] = 16'h0304;
    res[16*3 +: 16] = 16'h0506;
    res[16*4 +: 16] = 16'h0708;
    clear_obs();
    busy_len = 10;
    pulse_load(res, 2);
    tests++; if (tx_start !== 1'b1 || tx_data !== 8'hA5) begin
      fails++; $display("FAIL n2_first_start_latency got start=%b data=%h exp start=1 data=a5", tx_start, tx_data);
    end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL n2_busy got %b exp 1", busy); end
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL n2_done_timeout got no done exp done"); end
    @(negedge bclk);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL n2_after_done got done=%b busy=%b exp 0 0", done, busy);
    end
    tests++; if (got_q.size() != 11) begin
      fails++; $display("FAIL n2_len got %0d exp 11", got_q.size());
    end else begin
      foreach (lit[i]) begin
        tests++; if (got_q[i] !== lit[i]) begin fails++; $display("FAIL n2_byte%0d got %h exp %h", i, got_q[i], lit[i]); end
      end
    end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL n2_err got %b exp 0", err); end
  endtask

  task automatic test_n3_incr();
    logic [143:0] res;
    bit           ok;
    for (int k = 0; k < 9; k++) res[16*k +: 16] = 16'h1100 + 16'(k);
    build_expected(res, 3);
    clear_obs();
    busy_len = 4;
    pulse_load(res, 3);
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL n3_done_timeout got no done exp done"); end
    tests++; if (got_q.size() != 21) begin
      fails++; $display("FAIL n3_len got %0d exp 21", got_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL n3_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL n3_err got %b exp 0", err); end
  endtask

  task automatic test_bad_size_and_n1();
    logic [143:0] res;
    bit           ok;
    int           bad [2];
    bad = '{0, 7};
    rand_result(res);
    foreach (bad[j]) begin
      clear_obs();
      pulse_load(res, bad[j]);
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL badsize%0d_err got %b exp 1", bad[j], err); end
      repeat (20) @(negedge bclk);
      tests++; if (start_cnt != 0 || busy !== 1'b0) begin
        fails++; $display("FAIL badsize%0d_idle got starts=%0d busy=%b exp 0 0", bad[j], start_cnt, busy);
      end
    end
    build_expected(res, 1);
    clear_obs();
    busy_len = 2;
    pulse_load(res, 1);
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL n1_err_cleared got %b exp 0", err); end
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL n1_done_timeout got no done exp done"); end
    tests++; if (got_q.size() != 5) begin
      fails++; $display("FAIL n1_len got %0d exp 5", got_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL n1_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_random_frames();
    logic [143:0] res;
    bit           ok;
    int           n;
    for (int it = 0; it < 4; it++) begin
      rand_result(res);
      n = int'($urandom_range(1, 3));
      build_expected(res, n);
      clear_obs();
      busy_len = int'($urandom_range(1, 6));
      pulse_load(res, n);
      wait_done(ok);
      tests++; if (!ok) begin fails++; $display("FAIL rand%0d_done_timeout got no done exp done", it); end
      tests++; if (got_q.size() != exp_q.size()) begin
        fails++; $display("FAIL rand%0d_len got %0d exp %0d", it, got_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_byte%0d got %h exp %h", it, i, got_q[i], exp_q[i]); end
        end
      end
    end
  endtask

  task automatic test_ack_timeout();
    logic [143:0] res;
    bit           ok;
    rand_result(res);
    build_expected(res, 2);
    clear_obs();
    drop_at = 3;
    busy_len = 3;
    pulse_load(res, 2);
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL timeout_done_timeout got no done exp done"); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL timeout_err got %b exp 1", err); end
    tests++; if (start_cnt != exp_q.size() + 1) begin
      fails++; $display("FAIL timeout_starts got %0d exp %0d", start_cnt, exp_q.size() + 1);
    end else begin
      tests++; if (start_q[3] !== exp_q[2] || start_q[2] !== exp_q[2]) begin
        fails++; $display("FAIL timeout_reissue got %h,%h exp %h", start_q[2], start_q[3], exp_q[2]);
      end
    end
    tests++; if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL timeout_len got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL timeout_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reload_ignored();
    logic [143:0] res_a, res_b;
    bit           ok;
    rand_result(res_a);
    rand_result(res_b);
    build_expected(res_a, 3);
    clear_obs();
    busy_len = 3;
    pulse_load(res_a, 3);
    repeat (30) @(negedge bclk);
    pulse_load(res_b, 2);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reload_busy got %b exp 1", busy); end
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL reload_done_timeout got no done exp done"); end
    tests++; if (got_q.size() != exp_q.size()) begin
      fails++; $display("FAIL reload_len got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL reload_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_rst_mid_frame();
    logic [143:0] res;
    bit           ok, seen;
    rand_result(res);
    clear_obs();
    busy_len = 10;
    pulse_load(res, 3);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (start_cnt >= 5) begin ok = 1'b1; break; end
      @(negedge bclk);
    end
    tests++; if (!ok) begin fails++; $display("FAIL rst_mid_reach5 got starts=%0d exp 5", start_cnt); end
    repeat (3) @(negedge bclk);
    rst = 1'b1;
    #1;
    tests++; if (tx_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tx_data !== 8'h00) begin
      fails++; $display("FAIL rst_mid_outputs got start=%b busy=%b done=%b data=%h exp 0 0 0 00", tx_start, busy, done, tx_data);
    end
    seen = 1'b0;
    repeat (3) begin @(negedge bclk); if (done) seen = 1'b1; end
    rst = 1'b0;
    repeat (10) begin @(negedge bclk); if (done) seen = 1'b1; end
    tests++; if (seen) begin fails++; $display("FAIL rst_mid_no_done got done pulse exp none"); end
    rand_result(res);
    build_expected(res, 1);
    clear_obs();
    busy_len = 5;
    pulse_load(res, 1);
    wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rst_reload_done_timeout got no done exp done"); end
    tests++; if (got_q.size() != 5 || start_cnt != 5) begin
      fails++; $display("FAIL rst_reload_len got %0d/%0d exp 5/5", got_q.size(), start_cnt);
    end else begin
      foreach (exp_q[i]) begin
        tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL rst_reload_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
      end
    end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_reload_err got %b exp 0", err); end
  endtask

  initial begin
    test_reset();
    test_n2_fixed();
    test_n3_incr();
    test_bad_size_and_n1();
    test_random_frames();
    test_ack_timeout();
    test_reload_ignored();
    test_rst_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
